alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter PRIO_INIT, default 0, meaning: requester that holds round-robin priority after reset.
REQ-002 Parameter STAT_W, default 16, meaning: width of the grant counters (used only with ALU_ARB_STATS_EN).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 reqN_valid  in  1  requester N (N=0,1) presents an operation.
REQ-006 reqN_ready  out  1  requester N's operation is accepted this cycle.
REQ-007 reqN_op  in  4  ALU opcode of requester N.
REQ-008 reqN_shamt  in  5  shift field of requester N, forwarded unchanged to the ALU.
REQ-009 reqN_a / reqN_b  in  32  operands In1 / In2 of requester N.
REQ-010 rsp_valid  out  1  response register holds a result.
REQ-011 rsp_ready  in  1  consumer takes the response this cycle.
REQ-012 rsp_src  out  1  index of the requester that issued the response.
REQ-013 rsp_result  out  32  registered ALU result.
REQ-014 rsp_zero  out  1  registered flag: rsp_result equals 0.
REQ-015 stat_grantN  out  STAT_W  grant count of requester N (present only with ALU_ARB_STATS_EN).

Function
REQ-016 The block shares one combinational ALU between two requesters through a one-entry response register, with states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 out_free = !rsp_valid || rsp_ready; no grant occurs when out_free=0.
REQ-018 Grant when out_free=1: one valid requester gets the grant; with both valid, the priority requester gets it; with none valid, no grant.
REQ-019 After every grant to requester N, priority moves to requester 1-N; priority holds when no grant occurs.
REQ-020 reqN_ready = out_free && granted==N; transfer occurs on reqN_valid && reqN_ready; requesters hold op/shamt/operands stable until the transfer.
REQ-021 On transfer, the ALU evaluates the granted operands and, at that edge, rsp_result, rsp_zero = (result==0) and rsp_src load; latency is exactly 1 cycle.
REQ-022 Opcodes: 0000 add, 0001 sub, 0011 and, 0100 nor, 0101 or, 0110 xor, 0111 b<<a, 1000 a<<b, 1001 b>>a, 1010 a>>b, 1110 signed a<b, 1111 unsigned a<b; any other opcode returns 0.
REQ-023 Arithmetic is modulo 2^32; a shift amount of 32 or more yields 0; compares return 32'h1 or 32'h0.
REQ-024 While FULL and rsp_ready=0, all rsp_* outputs hold stable and both reqN_ready are 0.
REQ-025 Transitions: EMPTY->FULL on transfer; FULL->FULL on transfer with rsp_ready=1 (back-to-back, one op per cycle); FULL->EMPTY on rsp_ready=1 without transfer; otherwise the state holds.
REQ-026 rsp_ready while EMPTY is ignored.

Reset
REQ-027 rst_n=0 immediately forces rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_src=0, priority=PRIO_INIT and stat_grantN=0.
REQ-028 Reset during FULL discards the held response, which is never presented; operation resumes on the first edge after rst_n rises.

Configuration
REQ-029 With ALU_ARB_STATS_EN defined, stat_grant0 and stat_grant1 exist, each counts transfers of its requester and saturates at all-ones.
REQ-030 Without ALU_ARB_STATS_EN, the stat ports and counters are absent and all other behaviour is identical.

Structure
REQ-031 A shared package holds the 4-bit opcode constants of REQ-022, the EMPTY/FULL state encoding and the 32-bit data width constant.
REQ-032 The block instantiates exactly one sub-module, the existing combinational ALU ula, fed by a 2:1 operand mux selected by the grant.

Verification
REQ-033 Only req0, ADD a=5 b=7 -> next cycle rsp_valid=1, rsp_result=12, rsp_zero=0, rsp_src=0.
REQ-034 Both requesters valid continuously, rsp_ready=1, PRIO_INIT=0 -> rsp_src 0,1,0,1 on consecutive cycles, one response per cycle.
REQ-035 Response pending, rsp_ready=0 for 3 cycles -> reqN_ready=0 and rsp_* stable; rsp_ready=1 -> a new op is accepted in that same cycle.
REQ-036 SUB 9,9 -> result 0, zero 1; op 1110 with a=32'hFFFFFFFF, b=1 -> 1; op 1111 with the same operands -> 0; op 0010 -> 0.
REQ-037 rst_n low mid-cycle while FULL -> rsp_valid=0 without waiting for a clock edge; after release, priority=PRIO_INIT.
REQ-038 ALU_ARB_STATS_EN with STAT_W=4 and 20 transfers from req0 -> stat_grant0=15, stat_grant1=0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: data width, opcodes,
// response-register state encoding and the request bundle.
package alu_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int SH_W   = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLLV = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRLV = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} rsp_state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;
endpackage

// File: rtl/ula.sv
// Combinational ALU shared by both requesters; unknown opcodes return 0.
module ula
  import alu_arbiter_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic [DATA_W-1:0] result
);
  // shamt is carried for interface compatibility; no supported opcode uses it
  logic unused_shamt;
  assign unused_shamt = ^shamt;

  logic big1, big2;
  assign big1 = |in1[DATA_W-1:SH_W];
  assign big2 = |in2[DATA_W-1:SH_W];

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = in1 + in2;
      OP_SUB:  result = in1 - in2;
      OP_AND:  result = in1 & in2;
      OP_NOR:  result = ~(in1 | in2);
      OP_OR:   result = in1 | in2;
      OP_XOR:  result = in1 ^ in2;
      OP_SLLV: result = big1 ? '0 : in2 << in1[SH_W-1:0];
      OP_SLL:  result = big2 ? '0 : in1 << in2[SH_W-1:0];
      OP_SRLV: result = big1 ? '0 : in2 >> in1[SH_W-1:0];
      OP_SRL:  result = big2 ? '0 : in1 >> in2[SH_W-1:0];
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(in1) < $signed(in2)};
      OP_SLTU: result = {{(DATA_W-1){1'b0}}, in1 < in2};
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters behind a
// one-entry response register. ALU_ARB_STATS_EN adds saturating grant counters.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic PRIO_INIT = 1'b0,
  parameter int   STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [4:0]        req0_shamt,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [4:0]        req1_shamt,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_src,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_grant0,
  output logic [STAT_W-1:0] stat_grant1
`endif
);
  rsp_state_t        state, state_nxt;
  logic              prio, out_free, gnt_any, gnt_idx, xfer;
  alu_req_t          sel;
  logic [DATA_W-1:0] alu_res;

  assign rsp_valid = (state == FULL);
  assign out_free  = !rsp_valid || rsp_ready;

  // Contention goes to the priority holder; otherwise whoever is valid
  assign gnt_any = req0_valid || req1_valid;
  assign gnt_idx = (req0_valid && req1_valid) ? prio : req1_valid;
  assign xfer    = out_free && gnt_any;

  assign req0_ready = xfer && !gnt_idx;
  assign req1_ready = xfer &&  gnt_idx;

  assign sel = gnt_idx ? alu_req_t'{req1_op, req1_shamt, req1_a, req1_b}
                       : alu_req_t'{req0_op, req0_shamt, req0_a, req0_b};

  ula u_ula (
    .op     (sel.op),
    .shamt  (sel.shamt),
    .in1    (sel.a),
    .in2    (sel.b),
    .result (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (xfer)           state_nxt = FULL;
    else if (rsp_ready) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio       <= PRIO_INIT;
      rsp_src    <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (xfer) begin
      prio       <= !gnt_idx;
      rsp_src    <= gnt_idx;
      rsp_result <= alu_res;
      rsp_zero   <= (alu_res == '0);
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
    end else if (xfer) begin
      if (!gnt_idx && !(&stat_grant0)) stat_grant0 <= stat_grant0 + 1'b1;
      if ( gnt_idx && !(&stat_grant1)) stat_grant1 <= stat_grant1 + 1'b1;
    end
  end
`else
  logic [STAT_W-1:0] unused_stat;
  assign unused_stat = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: spec-level model compared every cycle, plus directed
// literal checks. Define ALU_ARB_STATS_EN to also exercise the grant counters.
module tb_alu_arbiter;
  localparam logic TB_PRIO = 1'b0;
  localparam int   TB_STAT_W = 4;

  logic        clk = 0, rst_n = 0;
  logic        req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_src, rsp_zero;
  logic [3:0]  req0_op = 0, req1_op = 0;
  logic [4:0]  req0_shamt = 0, req1_shamt = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [TB_STAT_W-1:0] stat_grant0, stat_grant1;
`endif

  int n_cmp = 0, n_bad = 0;

  alu_arbiter #(.PRIO_INIT(TB_PRIO), .STAT_W(TB_STAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_shamt(req0_shamt), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_shamt(req1_shamt), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the opcode table with wide arithmetic
  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] w;
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0011: return a & b;
      4'b0100: return ~(a | b);
      4'b0101: return a | b;
      4'b0110: return a ^ b;
      4'b0111: begin w = (a >= 32) ? 64'd0 : ({32'd0, b} << a); return w[31:0]; end
      4'b1000: begin w = (b >= 32) ? 64'd0 : ({32'd0, a} << b); return w[31:0]; end
      4'b1001: begin w = ({32'd0, b} >> a); return w[31:0]; end
      4'b1010: begin w = ({32'd0, a} >> b); return w[31:0]; end
      4'b1110: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1111: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Model state: response register contents, priority holder, grant counts
  logic        m_valid, m_src, m_zero, m_prio;
  logic [31:0] m_result;
  int          m_cnt0, m_cnt1;

  function automatic int winner(input logic v0, input logic v1, input logic p);
    if (v0 && v1) return int'(p);
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_valid <= 0; m_src <= 0; m_zero <= 0; m_result <= 0;
      m_prio <= TB_PRIO; m_cnt0 <= 0; m_cnt1 <= 0;
    end else begin
      w = winner(req0_valid, req1_valid, m_prio);
      if ((!m_valid || rsp_ready) && w >= 0) begin
        m_valid  <= 1;
        m_src    <= (w == 1);
        m_result <= (w == 1) ? model_alu(req1_op, req1_a, req1_b) : model_alu(req0_op, req0_a, req0_b);
        m_zero   <= ((w == 1) ? model_alu(req1_op, req1_a, req1_b) : model_alu(req0_op, req0_a, req0_b)) == 0;
        m_prio   <= (w == 0);
        if (w == 0 && m_cnt0 < (1 << TB_STAT_W) - 1) m_cnt0 <= m_cnt0 + 1;
        if (w == 1 && m_cnt1 < (1 << TB_STAT_W) - 1) m_cnt1 <= m_cnt1 + 1;
      end else if (rsp_ready) begin
        m_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    bit free;
    free = !m_valid || rsp_ready;
    w = winner(req0_valid, req1_valid, m_prio);
    check("req0_ready", {31'd0, req0_ready}, {31'd0, free && w == 0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, free && w == 1});
    check("rsp_valid",  {31'd0, rsp_valid},  {31'd0, m_valid});
    if (m_valid) begin
      check("rsp_src",    {31'd0, rsp_src},  {31'd0, m_src});
      check("rsp_result", rsp_result,        m_result);
      check("rsp_zero",   {31'd0, rsp_zero}, {31'd0, m_zero});
    end
`ifdef ALU_ARB_STATS_EN
    check("stat_grant0", 32'(stat_grant0), 32'(m_cnt0));
    check("stat_grant1", 32'(stat_grant1), 32'(m_cnt1));
`endif
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; step(); step(); rst_n = 1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    step();
    check($sformatf("op%b_result", op), rsp_result, exp);
    check($sformatf("op%b_zero", op), {31'd0, rsp_zero}, {31'd0, exp == 0});
  endtask

  initial begin
    #12;
    check("rst_valid",  {31'd0, rsp_valid}, 32'd0);
    check("rst_result", rsp_result,         32'd0);
    check("rst_zero",   {31'd0, rsp_zero},  32'd0);
    check("rst_src",    {31'd0, rsp_src},   32'd0);
    step(); rst_n = 1;

    // Single ADD from req0
    req0_valid = 1; req0_op = 4'b0000; req0_a = 5; req0_b = 7; rsp_ready = 1;
    step();
    check("add_valid",  {31'd0, rsp_valid}, 32'd1);
    check("add_result", rsp_result,         32'd12);
    check("add_zero",   {31'd0, rsp_zero},  32'd0);
    check("add_src",    {31'd0, rsp_src},   32'd0);
    req0_valid = 0;
    step();

    // Both requesters streaming: strict alternation from PRIO_INIT
    do_reset();
    req0_valid = 1; req0_op = 4'b0000; req0_a = 1;  req0_b = 1;
    req1_valid = 1; req1_op = 4'b0000; req1_a = 10; req1_b = 10;
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_src",    {31'd0, rsp_src}, 32'(i % 2));
      check("rr_result", rsp_result,       (i % 2) ? 32'd20 : 32'd2);
    end

    // Back-pressure: response held, no readiness, then same-cycle accept
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_src",    {31'd0, rsp_src},    32'd1);
      check("bp_result", rsp_result,          32'd20);
      check("bp_ready0", {31'd0, req0_ready}, 32'd0);
      check("bp_ready1", {31'd0, req1_ready}, 32'd0);
    end
    rsp_ready = 1; #1;
    check("bp_rel_ready0", {31'd0, req0_ready}, 32'd1);
    check("bp_rel_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    check("bp_rel_src",    {31'd0, rsp_src}, 32'd0);
    check("bp_rel_result", rsp_result,       32'd2);
    req1_valid = 0;

    // Opcode table
    run_op(4'b0001, 32'd9, 32'd9, 32'd0);
    run_op(4'b1110, 32'hFFFFFFFF, 32'd1, 32'd1);
    run_op(4'b1111, 32'hFFFFFFFF, 32'd1, 32'd0);
    run_op(4'b0010, 32'd5, 32'd3, 32'd0);
    run_op(4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0);
    run_op(4'b0011, 32'hF0, 32'h3C, 32'h30);
    run_op(4'b0100, 32'd0, 32'd0, 32'hFFFFFFFF);
    run_op(4'b0101, 32'hF0, 32'h0F, 32'hFF);
    run_op(4'b0110, 32'hFF, 32'h0F, 32'hF0);
    run_op(4'b0111, 32'd4, 32'd1, 32'd16);
    run_op(4'b1000, 32'd1, 32'd40, 32'd0);
    run_op(4'b1001, 32'd4, 32'h80000000, 32'h08000000);
    run_op(4'b1010, 32'h80, 32'd4, 32'd8);
    run_op(4'b1100, 32'd7, 32'd7, 32'd0);

    // Async reset while FULL, then priority returns to PRIO_INIT
    req0_op = 4'b0000; req0_a = 1; req0_b = 2;
    step();
    req0_valid = 0; rsp_ready = 0;
    #2 rst_n = 0;
    #1;
    check("arst_valid",  {31'd0, rsp_valid}, 32'd0);
    check("arst_result", rsp_result,         32'd0);
    step();
    rst_n = 1;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1; #1;
    check("arst_prio0", {31'd0, req0_ready}, 32'd1);
    check("arst_prio1", {31'd0, req1_ready}, 32'd0);
    step();
    check("arst_src", {31'd0, rsp_src}, 32'd0);
    req1_valid = 0;

`ifdef ALU_ARB_STATS_EN
    do_reset();
    req0_valid = 1; rsp_ready = 1;
    for (int i = 0; i < 20; i++) step();
    check("stat0_sat", 32'(stat_grant0), 32'd15);
    check("stat1_zero", 32'(stat_grant1), 32'd0);
`endif

    req0_valid = 0; req1_valid = 0;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
